aes_256_dec_iter: RTL and testbench

Iterative AES-256 inverse cipher, the decrypt-side counterpart of the team's pipelined `aes_256` encrypt core. It accepts one 128-bit ciphertext plus the final 256 bits of the expanded key schedule. It then runs the 14 inverse rounds one per cycle, regenerating round keys backwards on the fly. It sits behind the same `regchain` I/O retiming used by the encrypt top, but adds a valid/ready handshake, so it never needs a full key pipeline.

---
 rtl/aes_256_dec_iter.sv | 201 ++++++++++++++++++++
 tb/tb_aes_256_dec_iter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_256_dec_iter.sv
// Iterative AES-256 inverse cipher: one inverse round per cycle, round keys
// regenerated backwards from the last two round keys supplied on DKEY.

package aes_256_dec_iter_pkg;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

endpackage

// Forward AES S-box.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_256_dec_iter_pkg::*;
  always_comb y = affine_fwd(gf_inv(a));
endmodule

// Inverse AES S-box.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_256_dec_iter_pkg::*;
  always_comb y = gf_inv(affine_inv(a));
endmodule

module aes_256_dec_iter (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] CT,
  input  logic [255:0] DKEY,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] PT,
  output logic         BUSY
);
  import aes_256_dec_iter_pkg::*;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] ka_q, ka_d;
  logic [127:0] kb_q, kb_d;
  logic [3:0]   r_q, r_d;

  logic [127:0] sr, sb, t, mc;
  logic [31:0]  p, hin, sw, h;
  logic [7:0]   rcon;
  logic [127:0] key_prev;

  // Byte b of the state lives at [127-8b -: 8]; row = b%4, column = b/4.
  always_comb begin
    sr = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned rr = 0; rr < 4; rr++) begin
        sr[127-8*(4*c+rr) -: 8] = st_q[127-8*(4*((c+4-rr)%4)+rr) -: 8];
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_isb
    inv_sbox u_isb (.a(sr[8*i +: 8]), .y(sb[8*i +: 8]));
  end

  assign t = sb ^ ka_q;

  always_comb begin
    mc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mc[127-32*c -: 8] = gf_mul(t[127-32*c -: 8], 8'h0e) ^ gf_mul(t[119-32*c -: 8], 8'h0b)
                        ^ gf_mul(t[111-32*c -: 8], 8'h0d) ^ gf_mul(t[103-32*c -: 8], 8'h09);
      mc[119-32*c -: 8] = gf_mul(t[127-32*c -: 8], 8'h09) ^ gf_mul(t[119-32*c -: 8], 8'h0e)
                        ^ gf_mul(t[111-32*c -: 8], 8'h0b) ^ gf_mul(t[103-32*c -: 8], 8'h0d);
      mc[111-32*c -: 8] = gf_mul(t[127-32*c -: 8], 8'h0d) ^ gf_mul(t[119-32*c -: 8], 8'h09)
                        ^ gf_mul(t[111-32*c -: 8], 8'h0e) ^ gf_mul(t[103-32*c -: 8], 8'h0b);
      mc[103-32*c -: 8] = gf_mul(t[127-32*c -: 8], 8'h0b) ^ gf_mul(t[119-32*c -: 8], 8'h0d)
                        ^ gf_mul(t[111-32*c -: 8], 8'h09) ^ gf_mul(t[103-32*c -: 8], 8'h0e);
    end
  end

  // Backward key step: ka holds w[4r..4r+3], kb holds w[4r+4..4r+7];
  // odd r means round key r-1 starts on a multiple of 8 (RotWord + Rcon).
  assign p   = ka_q[31:0];
  assign hin = r_q[0] ? {p[23:0], p[31:24]} : p;

  for (genvar i = 0; i < 4; i++) begin : g_ksb
    aes_sbox u_sb (.a(hin[8*i +: 8]), .y(sw[8*i +: 8]));
  end

  always_comb begin
    rcon = 8'h00;
    unique case (r_q)
      4'd1:    rcon = 8'h01;
      4'd3:    rcon = 8'h02;
      4'd5:    rcon = 8'h04;
      4'd7:    rcon = 8'h08;
      4'd9:    rcon = 8'h10;
      4'd11:   rcon = 8'h20;
      4'd13:   rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  assign h        = sw ^ {rcon, 24'h0};
  assign key_prev = {kb_q[127:96] ^ h,
                     kb_q[95:64]  ^ kb_q[127:96],
                     kb_q[63:32]  ^ kb_q[95:64],
                     kb_q[31:0]   ^ kb_q[63:32]};

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          st_d    = CT ^ DKEY[127:0];
          ka_d    = DKEY[255:128];
          kb_d    = DKEY[127:0];
          r_d     = 4'd13;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d = (r_q == 4'd0) ? t : mc;
        kb_d = ka_q;
        ka_d = key_prev;
        r_d  = r_q - 4'd1;
        if (r_q == 4'd0) state_d = DONE;
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      st_q    <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      r_q     <= r_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign BUSY      = (state_q != IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign PT        = st_q;

endmodule

// File: tb/tb_aes_256_dec_iter.sv
// Bench for aes_256_dec_iter: a forward AES-256 model encrypts plaintexts,
// and a cycle-level handshake model predicts every output of the decryptor.
module tb_aes_256_dec_iter;

  logic         CLK = 1'b0;
  logic         RSTN;
  logic         IN_VALID;
  logic         IN_READY;
  logic [127:0] CT;
  logic [255:0] DKEY;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [127:0] PT;
  logic         BUSY;

  logic or_man, or_rand, rnd_mode;
  assign OUT_READY = rnd_mode ? or_rand : or_man;

  aes_256_dec_iter dut (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .CT(CT), .DKEY(DKEY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .PT(PT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_t [256];
  logic [7:0]   isbox_t[256];
  logic [127:0] cur_rk [15];
  logic [127:0] in_exp;

  logic         m_busy = 1'b0;
  int           m_cnt  = 0;
  logic [127:0] m_pt   = '0;
  logic [127:0] m_rk [15];
  int           m_acc  = 0;
  logic         chk_on = 1'b0;
  int           cyc    = 0;
  int           dut_acc_cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return bmul(a, 8'h02);
  endfunction

  // S-box from its definition: brute-force field inverse then the affine map.
  task automatic build_tables();
    logic [7:0] inv, s, c, xb, yb;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = y[7:0];
        if (bmul(xb, yb) == 8'h01) inv = yb;
      end
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
    for (int x = 0; x < 256; x++) begin
      xb = x[7:0];
      isbox_t[sbox_t[x]] = xb;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] k);
    logic [31:0] w[60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int j = 0; j < 15; j++) cur_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s[16], u[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k, o;
    k = cur_rk[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int i = 0; i < 16; i++) u[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = u[4*((c+r)%4)+r];
      if (rnd < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      k = cur_rk[rnd];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Handshake model: accept when idle, 14 rounds, then hold until taken.
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_pt   <= '0;
    end else if (!m_busy) begin
      if (IN_VALID) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_pt   <= in_exp;
        for (int j = 0; j < 15; j++) m_rk[j] <= cur_rk[j];
        m_acc  <= m_acc + 1;
      end
    end else if (m_cnt < 14) begin
      m_cnt <= m_cnt + 1;
    end else if (OUT_READY) begin
      m_busy <= 1'b0;
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RSTN && IN_VALID && IN_READY) dut_acc_cyc <= cyc;
  end

  always @(negedge CLK) begin
    if (chk_on && RSTN) begin
      chk1("in_ready", IN_READY, !m_busy);
      chk1("busy", BUSY, m_busy);
      chk1("out_valid", OUT_VALID, m_busy && (m_cnt == 14));
      if (m_busy && m_cnt == 14) chk("pt", PT, m_pt);
      if (m_busy && m_cnt <= 13) chk("ka_round", dut.ka_q, m_rk[13-m_cnt]);
    end
  end

  initial begin
    or_rand = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      or_rand = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic present(input logic [127:0] pt, input logic [255:0] key);
    expand(key);
    CT       = aes_enc(pt);
    DKEY     = {cur_rk[13], cur_rk[14]};
    in_exp   = pt;
    IN_VALID = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int  start;
    bit  ok;
    start = m_acc;
    ok    = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge CLK);
      #1;
      if (m_acc != start) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no accept within 200 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge CLK);
      #1;
      if (!m_busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: not idle within 200 cycles", name);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int prev;
    logic [127:0] r0, r1;
    RSTN = 1'b0; IN_VALID = 1'b0; CT = '0; DKEY = '0; in_exp = '0;
    or_man = 1'b1; rnd_mode = 1'b0;
    build_tables();

    chk("model_sbox00", {120'h0, sbox_t[8'h00]}, 128'h63);
    chk("model_sbox53", {120'h0, sbox_t[8'h53]}, 128'hed);
    chk("model_isbox16", {120'h0, isbox_t[8'h16]}, 128'hff);

    @(posedge CLK);
    #1;
    chk("rst_pt", PT, 128'h0);
    chk1("rst_in_ready", IN_READY, 1'b1);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_out_valid", OUT_VALID, 1'b0);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    chk_on = 1'b1;

    present(128'h00112233445566778899aabbccddeeff,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    chk("model_fips_c3", CT, 128'h8ea2b7ca516745bfeafc49904b496089);
    wait_accept("fips");
    IN_VALID = 1'b0;
    wait_idle("fips");

    present(rnd128(), '0);
    wait_accept("key_zero");
    IN_VALID = 1'b0;
    wait_idle("key_zero");
    present(rnd128(), '1);
    wait_accept("key_ones");
    IN_VALID = 1'b0;
    wait_idle("key_ones");

    or_man = 1'b0;
    present(rnd128(), {rnd128(), rnd128()});
    wait_accept("bp_first");
    present(rnd128(), {rnd128(), rnd128()});
    repeat (64) @(posedge CLK);
    #1;
    or_man = 1'b1;
    wait_accept("bp_second");
    IN_VALID = 1'b0;
    wait_idle("bp");

    prev = 0;
    for (int k = 0; k < 4; k++) begin
      present(rnd128(), {rnd128(), rnd128()});
      wait_accept("b2b");
      if (k > 0) chki("b2b_gap", dut_acc_cyc - prev, 16);
      prev = dut_acc_cyc;
    end
    IN_VALID = 1'b0;
    wait_idle("b2b");

    present(rnd128(), {rnd128(), rnd128()});
    wait_accept("rst_mid");
    IN_VALID = 1'b0;
    repeat (7) @(posedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    chk1("arst_busy", BUSY, 1'b0);
    chk1("arst_in_ready", IN_READY, 1'b1);
    chk1("arst_out_valid", OUT_VALID, 1'b0);
    #1;
    RSTN = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    present(rnd128(), {rnd128(), rnd128()});
    wait_accept("after_rst");
    IN_VALID = 1'b0;
    wait_idle("after_rst");

    rnd_mode = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      r0 = rnd128();
      r1 = rnd128();
      present(rnd128(), {r0, r1});
      wait_accept("random");
    end
    IN_VALID = 1'b0;
    wait_idle("random");
    rnd_mode = 1'b0;
    repeat (3) @(posedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
